// File: rtl/clk_en_synth_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_synth_if
// Description : Configuration and strobe bundle for clk_en_synth.
//               master : drives cfg_valid / cfg_ch / cfg_inc and observes
//                        cfg_ready / ce_out / locked.
//               slave  : the synthesizer side.
//               Signals:
//                 cfg_valid  configuration write request
//                 cfg_ready  a write can be accepted this cycle
//                 cfg_ch     target channel index (3 bits)
//                 cfg_inc    new phase increment (ACC_W bits)
//                 ce_out     per-channel one-cycle clock-enable strobes
//                 locked     all channels settled, strobes valid
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_en_synth_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 32
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [NUM_CH-1:0] ce_out;
  logic              locked;

  modport master (
    output cfg_valid, cfg_ch, cfg_inc,
    input  cfg_ready, ce_out, locked
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_inc,
    output cfg_ready, ce_out, locked
  );
endinterface
`default_nettype wire

// File: rtl/clk_en_synth.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_synth
// Description : Multi-channel clock-enable synthesizer. Each channel is a
//               phase accumulator whose carry-out, registered, becomes a
//               one-cycle enable strobe at rate f_refclk * inc / 2^ACC_W.
//               A HOLD/SETTLE/LOCKED controller masks the strobes for
//               LOCK_CYCLES cycles after reset and after every accepted
//               configuration write.
// Ports       : refclk  sole clock, rising edge
//               rst     synchronous active-high reset
//               bus     clk_en_synth_if.slave (cfg_valid, cfg_ready, cfg_ch,
//                       cfg_inc, ce_out, locked)
// Config      : define CES_PHASE_ALIGN_EN to clear every accumulator on an
//               accepted write (phase-aligned restart); otherwise only the
//               addressed channel's accumulator is cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_en_synth #(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16
) (
  input  wire logic     refclk,
  input  wire logic     rst,
  clk_en_synth_if.slave bus
);

  localparam int                 c_CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_locked;
  logic               r_ready;

  logic               w_accept;
  logic               w_ch_ok;
  logic               w_wr;
  logic [NUM_CH-1:0]  w_carry;

  // cfg_ready is only high in LOCKED, so an accepted write implies LOCKED.
  assign w_accept = bus.cfg_valid & r_ready;
  assign w_ch_ok  = ({29'd0, bus.cfg_ch} < 32'(NUM_CH));
  // Out-of-range channels are accepted but change nothing.
  assign w_wr     = w_accept & w_ch_ok;

  // --------------------------------------------------------------------------
  // Lock controller
  // --------------------------------------------------------------------------
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state  <= HOLD;
      r_cnt    <= c_CNT_INIT;
      r_locked <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        HOLD, SETTLE: begin
          if (r_cnt == '0) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
            r_ready  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        LOCKED: begin
          if (w_wr) begin
            r_state  <= SETTLE;
            r_cnt    <= c_CNT_INIT;
            r_locked <= 1'b0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_state  <= HOLD;
          r_cnt    <= c_CNT_INIT;
          r_locked <= 1'b0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Phase-accumulator channels
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [ACC_W-1:0] r_inc;
      logic [ACC_W-1:0] r_acc;
      logic             r_carry;
      logic [ACC_W:0]   w_sum;
      logic             w_hit;
      logic             w_clr;

      assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
      assign w_hit = w_wr & (bus.cfg_ch == 3'(i));
`ifdef CES_PHASE_ALIGN_EN
      assign w_clr = w_wr;
`else
      assign w_clr = w_hit;
`endif

      // The carry is captured even on a clearing cycle; it is hidden by the
      // lock mask because locked falls on the same edge.
      always_ff @(posedge refclk) begin
        if (rst) begin
          r_inc   <= '0;
          r_acc   <= '0;
          r_carry <= 1'b0;
        end else begin
          r_carry <= w_sum[ACC_W];
          if (w_hit) begin
            r_inc <= bus.cfg_inc;
          end
          r_acc <= w_clr ? '0 : w_sum[ACC_W-1:0];
        end
      end

      assign w_carry[i] = r_carry;
    end
  endgenerate

  assign bus.ce_out    = w_carry & {NUM_CH{r_locked}};
  assign bus.locked    = r_locked;
  assign bus.cfg_ready = r_ready;

endmodule
`default_nettype wire
